// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// ---------------------------------------------------------------------------
// Scan controller for a 4-digit time-multiplexed 7-segment display.
// Each digit gets one slot of REFRESH_DIV clocks. In its slot the digit's
// 5-bit code goes to the segment decoder and its active-low anode is driven.
// A new 4-digit frame is captured through a load strobe. It is kept in a
// staging buffer and only becomes the displayed frame at a frame boundary
// (the last cycle of slot 3), so a visible frame never tears.
//
// Optional build macro: SCAN_DEADTIME_EN
//   When defined, the anodes stay off for the first DEAD_CYCLES clocks of
//   every slot to suppress ghosting. code_out and digit_idx still switch at
//   the slot start.
//
// Parameters:
//   REFRESH_DIV  clocks per digit slot (4 .. 2^20)
//   DEAD_CYCLES  anode-off guard clocks per slot (< REFRESH_DIV)
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous active-high reset
//   load            one-cycle strobe that captures digit_codes_in/blank_mask
//   digit_codes_in  digit k code in bits [5k+4:5k], digit 0 is rightmost
//   blank_mask      bit k forces digit k blank
//   load_ack        pulse on the first cycle a captured frame is displayed
//   code_out        code for the current digit (16 = blank)
//   an              active-low anode selects
//   digit_idx       index of the current slot
//   frame_tick      pulse on the last cycle of slot 3
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [19:0] digit_codes_in,
  input  logic [3:0]  blank_mask,
  output logic        load_ack,
  output logic [4:0]  code_out,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  // The slot counter must hold both REFRESH_DIV-1 and the guard threshold.
  localparam int CNT_SPAN = (DEAD_CYCLES >= REFRESH_DIV) ? DEAD_CYCLES + 1 : REFRESH_DIV;
  localparam int CW = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [4:0] BLANK_CODE = 5'b10000;

  // IDLE is the state held in reset. The first clock after reset release
  // enters slot 0 with the counter at 0, so slot 0 gets its full length.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [19:0] dispCode_q, dispCode_d;
  logic [3:0]  dispBlank_q, dispBlank_d;
  logic [19:0] stageCode_q, stageCode_d;
  logic [3:0]  stageBlank_q, stageBlank_d;
  logic        pending_q, pending_d;
  logic        ack_q, ack_d;
  logic        tick_q, tick_d;
  logic [3:0]  an_q, an_d;
  logic [4:0]  code_q, code_d;

  logic        boundary;
  logic        swap;
  logic [4:0]  selCode;
  logic        selBlank;

  // Next-state logic. The counter and digit index describe the slot that
  // will be visible after the next edge. All outputs are computed from those
  // next-state values so the registered outputs stay aligned with the slot.
  always_comb begin
    state_d      = ST_SCAN;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    dispCode_d   = dispCode_q;
    dispBlank_d  = dispBlank_q;
    stageCode_d  = stageCode_q;
    stageBlank_d = stageBlank_q;
    pending_d    = pending_q;

    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // The current cycle is the last cycle of slot 3 (frame_tick is high).
    boundary = (state_q == ST_SCAN) && (cnt_q == CNT_LAST) && (idx_q == 2'd3);
    swap     = boundary && (pending_q || load);

    if (load) begin
      stageCode_d  = digit_codes_in;
      stageBlank_d = blank_mask;
      pending_d    = 1'b1;
    end

    // A load in the boundary cycle bypasses the staging buffer so it is
    // shown immediately in the next frame. Either way only one ack results.
    if (swap) begin
      dispCode_d  = load ? digit_codes_in : stageCode_q;
      dispBlank_d = load ? blank_mask : stageBlank_q;
      pending_d   = 1'b0;
    end

    ack_d  = swap;
    tick_d = (cnt_d == CNT_LAST) && (idx_d == 2'd3);

    case (idx_d)
      2'd0:    begin selCode = dispCode_d[4:0];   selBlank = dispBlank_d[0]; end
      2'd1:    begin selCode = dispCode_d[9:5];   selBlank = dispBlank_d[1]; end
      2'd2:    begin selCode = dispCode_d[14:10]; selBlank = dispBlank_d[2]; end
      default: begin selCode = dispCode_d[19:15]; selBlank = dispBlank_d[3]; end
    endcase
    code_d = selBlank ? BLANK_CODE : selCode;

    an_d        = 4'b1111;
    an_d[idx_d] = 1'b0;
`ifdef SCAN_DEADTIME_EN
    if (cnt_d < CW'(DEAD_CYCLES)) begin
      an_d = 4'b1111;
    end
`endif
  end

  // State and output registers. Reset discards both frames (all digits
  // blank) and any pending load, so no ack can follow a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      dispCode_q   <= '0;
      dispBlank_q  <= 4'b1111;
      stageCode_q  <= '0;
      stageBlank_q <= 4'b1111;
      pending_q    <= 1'b0;
      ack_q        <= 1'b0;
      tick_q       <= 1'b0;
      an_q         <= 4'b1111;
      code_q       <= BLANK_CODE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      dispCode_q   <= dispCode_d;
      dispBlank_q  <= dispBlank_d;
      stageCode_q  <= stageCode_d;
      stageBlank_q <= stageBlank_d;
      pending_q    <= pending_d;
      ack_q        <= ack_d;
      tick_q       <= tick_d;
      an_q         <= an_d;
      code_q       <= code_d;
    end
  end

  assign load_ack   = ack_q;
  assign code_out   = code_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver
// ---------------------------------------------------------------------------
// Bench for seg_scan_driver with REFRESH_DIV=4 and DEAD_CYCLES=2.
// A behavioural model counts clocks since reset release. It derives the
// slot and position arithmetically, and it keeps the displayed and staged
// frames as small arrays. Directed vectors walk through the scan order,
// delayed frame swap, load overwrite, load on the boundary cycle, blanking
// and reset with a pending frame. Hand-computed literals pin key cycles.
// Build macro SCAN_DEADTIME_EN is honoured by both the model and the pins.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int REFRESH_DIV = 4;
  localparam int DEAD_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [19:0] digitCodesIn;
  logic [3:0]  blankMask;
  logic        loadAck;
  logic [4:0]  codeOut;
  logic [3:0]  an;
  logic [1:0]  digitIdx;
  logic        frameTick;

  int vectorCount = 0;
  int missCount   = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .REFRESH_DIV(REFRESH_DIV),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .digit_codes_in(digitCodesIn),
    .blank_mask(blankMask),
    .load_ack(loadAck),
    .code_out(codeOut),
    .an(an),
    .digit_idx(digitIdx),
    .frame_tick(frameTick)
  );

  // Model state: mN is the number of clocks since reset release (0 in reset).
  int         mN = 0;
  bit         mStarted = 1'b0;
  logic [4:0] mDispCode [4];
  logic       mDispBlank [4];
  logic [4:0] mStageCode [4];
  logic       mStageBlank [4];
  logic       mPending;
  logic [3:0] expAn;
  logic [4:0] expCode;
  logic [1:0] expIdx;
  logic       expAck;
  logic       expTick;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s at t=%0t n=%0d: got %0h, expected %0h", name, $time, mN, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [19:0] codes, input logic [3:0] mask);
    load         = ld;
    digitCodesIn = codes;
    blankMask    = mask;
  endtask

  // Wait on falling edges until the model's clock count reaches target.
  task automatic gotoN(input int target);
    int guard = 0;
    while (mN != target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (mN != target) begin
      vectorCount++;
      missCount++;
      $display("[TB] FAIL gotoN: reached n=%0d, expected n=%0d", mN, target);
    end
  endtask

  // Behavioural model, evaluated on each rising edge using the inputs
  // the DUT sees on that edge.
  always @(posedge clk) begin : model
    int  slot;
    int  pos;
    bit  boundaryNow;
    mStarted = 1'b1;
    if (reset) begin
      mN = 0;
      for (int k = 0; k < 4; k++) begin
        mDispCode[k]   = 5'd0;
        mDispBlank[k]  = 1'b1;
        mStageCode[k]  = 5'd0;
        mStageBlank[k] = 1'b1;
      end
      mPending = 1'b0;
      expAck   = 1'b0;
    end else begin
      boundaryNow = (mN > 0) && ((mN - 1) % REFRESH_DIV == REFRESH_DIV - 1)
                    && (((mN - 1) / REFRESH_DIV) % 4 == 3);
      expAck = 1'b0;
      if (boundaryNow && (mPending || load)) begin
        for (int k = 0; k < 4; k++) begin
          mDispCode[k]  = load ? digitCodesIn[5*k +: 5] : mStageCode[k];
          mDispBlank[k] = load ? blankMask[k] : mStageBlank[k];
        end
        mPending = 1'b0;
        expAck   = 1'b1;
      end else if (load) begin
        for (int k = 0; k < 4; k++) begin
          mStageCode[k]  = digitCodesIn[5*k +: 5];
          mStageBlank[k] = blankMask[k];
        end
        mPending = 1'b1;
      end
      mN++;
    end

    if (mN == 0) begin
      expAn   = 4'b1111;
      expCode = 5'd16;
      expIdx  = 2'd0;
      expTick = 1'b0;
    end else begin
      slot  = ((mN - 1) / REFRESH_DIV) % 4;
      pos   = (mN - 1) % REFRESH_DIV;
      expAn = 4'b1111;
      expAn[slot] = 1'b0;
`ifdef SCAN_DEADTIME_EN
      if (pos < DEAD_CYCLES) expAn = 4'b1111;
`endif
      expCode = mDispBlank[slot] ? 5'd16 : mDispCode[slot];
      expIdx  = slot[1:0];
      expTick = (pos == REFRESH_DIV - 1) && (slot == 3);
    end
  end

  // Compare every cycle once the model has seen a clock edge.
  always @(negedge clk) begin
    if (mStarted) begin
      checkOutput("an", an, expAn);
      checkOutput("code_out", codeOut, expCode);
      checkOutput("digit_idx", digitIdx, expIdx);
      checkOutput("load_ack", loadAck, expAck);
      checkOutput("frame_tick", frameTick, expTick);
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    logic [3:0] anTab [4];
    logic [3:0] anWant;
    anTab[0] = 4'b1110;
    anTab[1] = 4'b1101;
    anTab[2] = 4'b1011;
    anTab[3] = 4'b0111;

    reset = 1'b1;
    applyStimulus(1'b0, 20'd0, 4'd0);
    repeat (3) @(negedge clk);
    checkOutput("pin_reset_an", an, 4'b1111);
    checkOutput("pin_reset_code", codeOut, 5'd16);
    checkOutput("pin_reset_idx", digitIdx, 2'd0);
    checkOutput("pin_reset_ack", loadAck, 1'b0);
    reset = 1'b0;

    // Scan order over the first frame, all digits blank.
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      anWant = anTab[(e - 1) / 4];
`ifdef SCAN_DEADTIME_EN
      if (((e - 1) % 4) < 2) anWant = 4'b1111;
`endif
      checkOutput("pin_scan_an", an, anWant);
      checkOutput("pin_scan_code", codeOut, 5'd16);
      checkOutput("pin_scan_tick", frameTick, (e == 16) ? 1'b1 : 1'b0);
    end

    // Load at counter 1 of slot 1; frame appears only after the boundary.
    gotoN(22);
    applyStimulus(1'b1, {5'h0F, 5'h0A, 5'h01, 5'h00}, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    checkOutput("pin_load_noswap", codeOut, 5'd16);
    gotoN(32);
    checkOutput("pin_boundary_tick", frameTick, 1'b1);
    checkOutput("pin_boundary_code", codeOut, 5'd16);
    @(negedge clk);
    checkOutput("pin_ack_first", loadAck, 1'b1);
    checkOutput("pin_digit0", codeOut, 5'h00);
    @(negedge clk);
    checkOutput("pin_ack_once", loadAck, 1'b0);
    gotoN(37);
    checkOutput("pin_digit1", codeOut, 5'h01);
    gotoN(41);
    checkOutput("pin_digit2", codeOut, 5'h0A);
    gotoN(45);
    checkOutput("pin_digit3", codeOut, 5'h0F);

    // Two loads in one frame: latest wins, single ack.
    gotoN(50);
    applyStimulus(1'b1, {4{5'h03}}, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    gotoN(55);
    applyStimulus(1'b1, {4{5'h1E}}, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    gotoN(64);
    checkOutput("pin_overwrite_noack", loadAck, 1'b0);
    @(negedge clk);
    checkOutput("pin_overwrite_ack", loadAck, 1'b1);
    checkOutput("pin_overwrite_code", codeOut, 5'd30);
    @(negedge clk);
    checkOutput("pin_overwrite_ack_end", loadAck, 1'b0);
    gotoN(77);
    checkOutput("pin_overwrite_slot3", codeOut, 5'd30);

    // Load exactly on the boundary cycle.
    gotoN(80);
    checkOutput("pin_edge_tick", frameTick, 1'b1);
    applyStimulus(1'b1, {5'h04, 5'h03, 5'h02, 5'h1F}, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    anWant = 4'b1110;
`ifdef SCAN_DEADTIME_EN
    anWant = 4'b1111;
`endif
    checkOutput("pin_edge_code", codeOut, 5'h1F);
    checkOutput("pin_edge_ack", loadAck, 1'b1);
    checkOutput("pin_edge_an", an, anWant);

    // Blank mask 1010.
    gotoN(85);
    applyStimulus(1'b1, {4{5'h07}}, 4'b1010);
    @(negedge clk);
    load = 1'b0;
    gotoN(97);
    checkOutput("pin_mask_d0", codeOut, 5'd7);
    gotoN(101);
    checkOutput("pin_mask_d1", codeOut, 5'd16);
    gotoN(105);
    checkOutput("pin_mask_d2", codeOut, 5'd7);
    gotoN(109);
    checkOutput("pin_mask_d3", codeOut, 5'd16);

    // Reset mid-slot 2 with a pending frame.
    gotoN(114);
    applyStimulus(1'b1, {4{5'h11}}, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    gotoN(122);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("pin_rst2_an", an, 4'b1111);
    checkOutput("pin_rst2_code", codeOut, 5'd16);
    checkOutput("pin_rst2_idx", digitIdx, 2'd0);
    checkOutput("pin_rst2_ack", loadAck, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checkOutput("pin_rst2_noack", loadAck, 1'b0);
      checkOutput("pin_rst2_blank", codeOut, 5'd16);
      if (i == 1) begin
        anWant = 4'b1110;
`ifdef SCAN_DEADTIME_EN
        anWant = 4'b1111;
`endif
        checkOutput("pin_rst2_restart", an, anWant);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed scan controller for the 4-digit 7-segment display. It produces the 5-bit code that feeds the segment decoder's number input, plus the active-low anode selects. It accepts a 4-digit frame of 5-bit codes through a load/ack handshake and applies new frames only at frame boundaries, so a displayed frame never tears.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); legal range 4..2^20.
DEAD_CYCLES, 1000, anode-off guard cycles at the start of each slot; used only with SCAN_DEADTIME_EN; must be < REFRESH_DIV.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
load  in  1  one-cycle strobe: capture digit_codes_in and blank_mask
digit_codes_in  in  20  digit k code = bits [5k+4:5k]; digit 0 is rightmost (an[0])
blank_mask  in  4  bit k=1 forces digit k blank
load_ack  out  1  one-cycle pulse when a captured frame becomes the displayed frame
code_out  out  5  code for the current digit; drives the decoder number input
an  out  4  active-low anode selects, one-hot-low while a slot is active
digit_idx  out  2  index of the current slot
frame_tick  out  1  one-cycle pulse on the last cycle of slot 3

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (reset). All outputs are registered.
- Reset values:
  - an=4'b1111, code_out=5'b10000 (blank: the decoder turns all segments off), digit_idx=0.
  - load_ack=0, frame_tick=0.
  - Refresh counter=0; displayed and staged frames all digits blank; pending=0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap edge, digit_idx increments mod 4 (3 wraps to 0).
- Slot outputs:
  - an, code_out and digit_idx update on the same edge.
  - First edge with reset low: an=4'b1110, code_out = displayed digit 0.
  - an[k]=0 only while digit_idx==k.
  - code_out = 5'b10000 if that digit's stored blank bit is 1; otherwise the stored code, passed through unmodified (codes 16..29 also blank in the decoder; 30 is the degree symbol, 31 is "L").
- Frame boundary: the cycle where counter==REFRESH_DIV-1 and digit_idx==3. frame_tick=1 exactly in that cycle.
- Handshake:
  - load=1 writes the staged frame (codes and blank mask) and sets pending.
  - load while pending overwrites the staged frame; latest wins and only one ack is issued.
  - At a frame boundary with pending=1 or load=1, the displayed frame takes the staged frame, or the current inputs if load=1 that cycle. pending clears, and load_ack=1 on the following cycle, aligned with digit 0 of the new frame.
  - A load on a non-boundary cycle never changes the displayed frame mid-frame.
- reset during a frame or with pending=1: everything returns to reset values; the staged frame is discarded and no ack is issued.
- There is no back-pressure; load is always accepted.

Optional Feature:
SCAN_DEADTIME_EN
- Defined: an=4'b1111 for counter values 0..DEAD_CYCLES-1 of every slot, to suppress ghosting. code_out and digit_idx still switch at the slot start. frame_tick and load_ack timing are unchanged.
- Undefined: no guard interval; an is active for the full slot. DEAD_CYCLES is ignored.

Test Plan:
1. REFRESH_DIV=4. Reset high 3 cycles, then low -> during reset an=1111, code_out=16. After release, an cycles 1110,1101,1011,0111 every 4 clks with all codes 16. frame_tick is high on clk 16 after release.
2. load=1 with codes {3:5'h0F, 2:5'h0A, 1:5'h01, 0:5'h00} and mask 0 at counter=1 of slot 1 -> display stays blank until the boundary. load_ack pulses once on the first cycle of slot 0, then code_out sequence is 00,01,0A,0F.
3. Two loads in one frame (first 5'h03 on all digits, then 5'h1E on all digits) -> a single load_ack, and all digits show 5'h1E (30).
4. load asserted exactly on the frame-boundary cycle with digit 0=5'h1F -> next cycle shows 1F on an=1110 with load_ack=1.
5. blank_mask=4'b1010 with codes 5'h07 on all digits -> code_out=16 in slots 1 and 3, 7 in slots 0 and 2.
6. Reset asserted with pending=1 mid-slot 2 -> the next cycle has reset values, no load_ack ever fires, and the display restarts blank from slot 0. With SCAN_DEADTIME_EN and DEAD_CYCLES=2, an=1111 for the first 2 clks of each slot.
